// File: rtl/i_decode_pkg.sv
// Shared RV32 decode constants: field widths, supported opcodes and the
// decoder FSM state encoding, also used by the instruction buffer side.
package i_decode_pkg;

   localparam int OPT_SIZE   = 7;
   localparam int FUNCT_SIZE = 3;
   localparam int REG_SIZE   = 5;

   localparam logic [OPT_SIZE-1:0] OPCODE_B = 7'b1100011;
   localparam logic [OPT_SIZE-1:0] OPCODE_L = 7'b0000011;
   localparam logic [OPT_SIZE-1:0] OPCODE_S = 7'b0100011;
   localparam logic [OPT_SIZE-1:0] OPCODE_I = 7'b0010011;
   localparam logic [OPT_SIZE-1:0] OPCODE_R = 7'b0110011;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      HOLD = 2'b01,
      SEND = 2'b10,
      COOL = 2'b11
   } state_e;

   function automatic logic opcode_supported(input logic [OPT_SIZE-1:0] opt);
      logic ok;
      case (opt)
         OPCODE_B, OPCODE_L, OPCODE_S, OPCODE_I, OPCODE_R: ok = 1'b1;
         default:                                          ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/i_decode_imm_gen.sv
// Combinational immediate generator: builds the sign-extended immediate for
// the supported RV32 formats; R-type and unknown opcodes yield zero.
module i_decode_imm_gen
   import i_decode_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] inst_i,
   input  logic [OPT_SIZE-1:0]   opt_i,
   output logic [DATA_WIDTH-1:0] imm_o
);

   logic sign_s;

   assign sign_s = inst_i[31];

   // Immediate assembly per instruction format
   always_comb begin
      imm_o = {DATA_WIDTH{1'b0}};
      case (opt_i)
         OPCODE_I, OPCODE_L: imm_o = {{(DATA_WIDTH-12){sign_s}}, inst_i[31:20]};
         OPCODE_S:           imm_o = {{(DATA_WIDTH-12){sign_s}}, inst_i[31:25], inst_i[11:7]};
         OPCODE_B:           imm_o = {{(DATA_WIDTH-13){sign_s}}, inst_i[31], inst_i[7],
                                      inst_i[30:25], inst_i[11:8], 1'b0};
         OPCODE_R:           imm_o = {DATA_WIDTH{1'b0}};
         default:            imm_o = {DATA_WIDTH{1'b0}};
      endcase
   end

endmodule

// File: rtl/i_decode.sv
// RV32 decode stage: accepts one instruction from fetch, registers its fields
// and hands them to the instruction buffer with a single-cycle valid pulse.
module i_decode
   import i_decode_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  if_valid,
   input  logic [DATA_WIDTH-1:0] if_inst,
   output logic                  if_ready,
   input  logic                  ib_vacant,
   output logic                  ib_valid,
   output logic [OPT_SIZE-1:0]   ib_opt,
   output logic [FUNCT_SIZE-1:0] ib_funct,
   output logic [REG_SIZE-1:0]   ib_rs1,
   output logic [REG_SIZE-1:0]   ib_rs2,
   output logic [REG_SIZE-1:0]   ib_rd,
   output logic [DATA_WIDTH-1:0] ib_imm,
   output logic                  illegal
);

   state_e                state_q;
   logic                  if_ready_q;
   logic                  ib_valid_q;
   logic                  illegal_q;
   logic [OPT_SIZE-1:0]   opt_q;
   logic [FUNCT_SIZE-1:0] funct_q;
   logic [REG_SIZE-1:0]   rs1_q;
   logic [REG_SIZE-1:0]   rs2_q;
   logic [REG_SIZE-1:0]   rd_q;
   logic [DATA_WIDTH-1:0] imm_q;

   logic [OPT_SIZE-1:0]   opt_d;
   logic [FUNCT_SIZE-1:0] funct_d;
   logic [REG_SIZE-1:0]   rs1_d;
   logic [REG_SIZE-1:0]   rs2_d;
   logic [REG_SIZE-1:0]   rd_d;
   logic [DATA_WIDTH-1:0] imm_d;
   logic                  legal_d;

   assign opt_d   = if_inst[6:0];
   assign funct_d = if_inst[14:12];
   assign rs1_d   = if_inst[19:15];
   assign legal_d = opcode_supported(opt_d);

   i_decode_imm_gen #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_imm_gen (
      .inst_i (if_inst),
      .opt_i  (opt_d),
      .imm_o  (imm_d)
   );

   // rs2 exists only for R/S/B, rd only for R/I/L; absent fields read as zero
   always_comb begin
      rs2_d = {REG_SIZE{1'b0}};
      rd_d  = {REG_SIZE{1'b0}};
      case (opt_d)
         OPCODE_R: begin
            rs2_d = if_inst[24:20];
            rd_d  = if_inst[11:7];
         end
         OPCODE_S, OPCODE_B: begin
            rs2_d = if_inst[24:20];
            rd_d  = {REG_SIZE{1'b0}};
         end
         OPCODE_I, OPCODE_L: begin
            rs2_d = {REG_SIZE{1'b0}};
            rd_d  = if_inst[11:7];
         end
         default: begin
            rs2_d = {REG_SIZE{1'b0}};
            rd_d  = {REG_SIZE{1'b0}};
         end
      endcase
   end

   // Handshake FSM with registered outputs; COOL lets ib_vacant settle after a pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         if_ready_q <= 1'b1;
         ib_valid_q <= 1'b0;
         illegal_q  <= 1'b0;
         opt_q      <= {OPT_SIZE{1'b0}};
         funct_q    <= {FUNCT_SIZE{1'b0}};
         rs1_q      <= {REG_SIZE{1'b0}};
         rs2_q      <= {REG_SIZE{1'b0}};
         rd_q       <= {REG_SIZE{1'b0}};
         imm_q      <= {DATA_WIDTH{1'b0}};
      end else if (flush) begin
         state_q    <= IDLE;
         if_ready_q <= 1'b1;
         ib_valid_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         illegal_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (if_valid) begin
                  if (legal_d) begin
                     opt_q      <= opt_d;
                     funct_q    <= funct_d;
                     rs1_q      <= rs1_d;
                     rs2_q      <= rs2_d;
                     rd_q       <= rd_d;
                     imm_q      <= imm_d;
                     if_ready_q <= 1'b0;
                     state_q    <= HOLD;
                  end else begin
                     illegal_q <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (ib_vacant) begin
                  ib_valid_q <= 1'b1;
                  state_q    <= SEND;
               end
            end
            SEND: begin
               ib_valid_q <= 1'b0;
               state_q    <= COOL;
            end
            COOL: begin
               if_ready_q <= 1'b1;
               state_q    <= IDLE;
            end
            default: begin
               state_q    <= IDLE;
               if_ready_q <= 1'b1;
               ib_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign if_ready = if_ready_q;
   assign ib_valid = ib_valid_q;
   assign illegal  = illegal_q;
   assign ib_opt   = opt_q;
   assign ib_funct = funct_q;
   assign ib_rs1   = rs1_q;
   assign ib_rs2   = rs2_q;
   assign ib_rd    = rd_q;
   assign ib_imm   = imm_q;

endmodule

// File: tb/tb_i_decode.sv
// Directed bench for i_decode: expected decodes are queued at stimulus time
// and matched against each ib_valid pulse by a negedge monitor.
module tb_i_decode;

   typedef struct packed {
      logic [6:0]  opt;
      logic [2:0]  funct;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        if_valid = 1'b0;
   logic [31:0] if_inst = 32'd0;
   logic        if_ready;
   logic        ib_vacant = 1'b0;
   logic        ib_valid;
   logic [6:0]  ib_opt;
   logic [2:0]  ib_funct;
   logic [4:0]  ib_rs1;
   logic [4:0]  ib_rs2;
   logic [4:0]  ib_rd;
   logic [31:0] ib_imm;
   logic        illegal;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb[$];

   localparam logic [31:0] ADDI = 32'h00510093;
   localparam logic [31:0] LW   = 32'hFFC2A183;
   localparam logic [31:0] SW   = 32'h0063A423;
   localparam logic [31:0] BEQ  = 32'hFE208CE3;
   localparam logic [31:0] ADD  = 32'h00628233;
   localparam logic [31:0] BAD  = 32'h0000007F;

   localparam exp_t E_ADDI = '{7'b0010011, 3'b000, 5'd2, 5'd0, 5'd1, 32'h00000005};
   localparam exp_t E_LW   = '{7'b0000011, 3'b010, 5'd5, 5'd0, 5'd3, 32'hFFFFFFFC};
   localparam exp_t E_SW   = '{7'b0100011, 3'b010, 5'd7, 5'd6, 5'd0, 32'h00000008};
   localparam exp_t E_BEQ  = '{7'b1100011, 3'b000, 5'd1, 5'd2, 5'd0, 32'hFFFFFFF8};
   localparam exp_t E_ADD  = '{7'b0110011, 3'b000, 5'd5, 5'd6, 5'd4, 32'h00000000};

   i_decode #(.DATA_WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .if_valid  (if_valid),
      .if_inst   (if_inst),
      .if_ready  (if_ready),
      .ib_vacant (ib_vacant),
      .ib_valid  (ib_valid),
      .ib_opt    (ib_opt),
      .ib_funct  (ib_funct),
      .ib_rs1    (ib_rs1),
      .ib_rs2    (ib_rs2),
      .ib_rd     (ib_rd),
      .ib_imm    (ib_imm),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Every ib_valid pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (ib_valid === 1'b1) begin
         chk("valid_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("opt",   32'(ib_opt),   32'(e.opt));
            chk("funct", 32'(ib_funct), 32'(e.funct));
            chk("rs1",   32'(ib_rs1),   32'(e.rs1));
            chk("rs2",   32'(ib_rs2),   32'(e.rs2));
            chk("rd",    32'(ib_rd),    32'(e.rd));
            chk("imm",   ib_imm,        e.imm);
         end
      end
   end

   task automatic wait_ready();
      for (int i = 0; i < 20; i++) begin
         if (if_ready === 1'b1) break;
         step();
      end
      chk("wait_ready", 32'(if_ready), 32'd1);
   endtask

   // Full accept -> pulse -> cool sequence with ib_vacant held high
   task automatic send(input logic [31:0] inst, input exp_t e);
      wait_ready();
      sb.push_back(e);
      if_valid = 1'b1;
      if_inst  = inst;
      step();
      if_valid = 1'b0;
      chk("hold_ready",  32'(if_ready), 32'd0);
      chk("hold_valid",  32'(ib_valid), 32'd0);
      step();
      chk("lat2_valid",  32'(ib_valid), 32'd1);
      step();
      chk("send_off",    32'(ib_valid), 32'd0);
      chk("cool_ready",  32'(if_ready), 32'd0);
      step();
      chk("idle_ready",  32'(if_ready), 32'd1);
   endtask

   initial begin
      int t1;
      int t2;

      // reset
      repeat (3) step();
      chk("rst_ready",   32'(if_ready), 32'd1);
      chk("rst_valid",   32'(ib_valid), 32'd0);
      chk("rst_illegal", 32'(illegal),  32'd0);
      chk("rst_opt",     32'(ib_opt),   32'd0);
      chk("rst_imm",     ib_imm,        32'd0);
      rst = 1'b0;
      step();

      // addi, then beq
      ib_vacant = 1'b1;
      send(ADDI, E_ADDI);
      send(BEQ, E_BEQ);

      // lw with sw waiting behind it: second accept exactly 4 cycles later
      wait_ready();
      sb.push_back(E_LW);
      sb.push_back(E_SW);
      if_valid = 1'b1;
      if_inst  = LW;
      t1 = cyc;
      step();
      if_inst = SW;
      for (int i = 0; i < 10; i++) begin
         if (if_ready === 1'b1) break;
         step();
      end
      t2 = cyc;
      step();
      if_valid = 1'b0;
      chk("accept_gap", 32'(t2 - t1), 32'd4);
      repeat (4) step();
      wait_ready();

      // backpressure in HOLD
      ib_vacant = 1'b0;
      sb.push_back(E_ADD);
      if_valid = 1'b1;
      if_inst  = ADD;
      step();
      if_valid = 1'b0;
      if_inst  = ADDI;
      for (int i = 0; i < 6; i++) begin
         chk("bp_valid", 32'(ib_valid), 32'd0);
         chk("bp_ready", 32'(if_ready), 32'd0);
         chk("bp_rd",    32'(ib_rd),    32'd4);
         step();
      end
      ib_vacant = 1'b1;
      step();
      chk("bp_pulse",     32'(ib_valid), 32'd1);
      step();
      chk("bp_pulse_end", 32'(ib_valid), 32'd0);
      chk("bp_ready1",    32'(if_ready), 32'd0);
      chk("bp_fields",    32'(ib_rs2),   32'd6);
      step();
      chk("bp_ready2",    32'(if_ready), 32'd1);

      // unsupported opcode
      if_valid = 1'b1;
      if_inst  = BAD;
      step();
      if_valid = 1'b0;
      chk("ill_pulse", 32'(illegal),  32'd1);
      chk("ill_ready", 32'(if_ready), 32'd1);
      chk("ill_valid", 32'(ib_valid), 32'd0);
      chk("ill_opt",   32'(ib_opt),   32'b0110011);
      step();
      chk("ill_once",  32'(illegal),  32'd0);
      send(ADDI, E_ADDI);

      // illegal coinciding with flush: flush wins
      if_valid = 1'b1;
      if_inst  = BAD;
      flush    = 1'b1;
      step();
      if_valid = 1'b0;
      flush    = 1'b0;
      chk("flush_ill", 32'(illegal),  32'd0);
      chk("flush_rdy", 32'(if_ready), 32'd1);

      // flush in HOLD: instruction dropped
      ib_vacant = 1'b0;
      if_valid  = 1'b1;
      if_inst   = SW;
      step();
      if_valid = 1'b0;
      chk("fh_hold", 32'(if_ready), 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fh_ready", 32'(if_ready), 32'd1);
      chk("fh_valid", 32'(ib_valid), 32'd0);
      ib_vacant = 1'b1;
      repeat (3) begin
         step();
         chk("fh_nopulse", 32'(ib_valid), 32'd0);
      end

      // reset mid-HOLD
      ib_vacant = 1'b0;
      if_valid  = 1'b1;
      if_inst   = LW;
      step();
      if_valid = 1'b0;
      chk("rh_hold", 32'(if_ready), 32'd0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rh_ready", 32'(if_ready), 32'd1);
      chk("rh_valid", 32'(ib_valid), 32'd0);
      chk("rh_opt",   32'(ib_opt),   32'd0);
      chk("rh_rd",    32'(ib_rd),    32'd0);
      chk("rh_imm",   ib_imm,        32'd0);
      ib_vacant = 1'b1;
      repeat (3) begin
         step();
         chk("rh_nopulse", 32'(ib_valid), 32'd0);
      end

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
